pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 STALL  input  1  decode not accepting; hold the current fetched instruction.
REQ-005 BR_TAKEN, BR_TARGET  input  1, 32  branch resolved taken, and its target.
REQ-006 JMP_VALID, JMP_TARGET  input  1, 32  JAL/JALR redirect, and its target.
REQ-007 TRAP, MTVEC  input  1, 32  trap entry request, and trap vector.
REQ-008 MRET, MEPC  input  1, 32  trap return request, and return address.
REQ-009 IMEM_REQ  output  1  fetch request to instruction memory.
REQ-010 IMEM_ADDR  output  32  fetch address; stable while IMEM_REQ=1 and IMEM_RDY=0.
REQ-011 IMEM_RDY  input  1  memory accepts/returns the fetch this cycle.
REQ-012 IF_PC  output  32  address of the instruction currently presented to decode.
REQ-013 IF_VALID  output  1  IF_PC/instruction valid for decode.
REQ-014 FLUSH  output  1  combinational; kill younger pipeline stages this cycle.
REQ-015 MISALIGN  output  1  one-cycle pulse; the accepted redirect target had bits[1:0]!=0.

Function
REQ-016 Internal registers: PC (next fetch address), FADDR (outstanding fetch address), state in {BOOT, FETCH, HOLD, DRAIN}.
REQ-017 Redirect = TRAP|MRET|BR_TAKEN|JMP_VALID; fixed priority TRAP > MRET > BR_TAKEN > JMP_VALID; exactly one target is selected.
REQ-018 Selected target SHALL be loaded into PC with bits[1:0] forced to 0; MISALIGN=1 that cycle if the original bits[1:0]!=0.
REQ-019 Sequential increment SHALL be PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-020 BOOT: IMEM_REQ=0, IF_VALID=0; redirect inputs ignored; next state FETCH with FADDR<=PC.
REQ-021 FETCH: IMEM_REQ=1, IMEM_ADDR=FADDR; no IMEM_RDY -> remain, FADDR held.
REQ-022 FETCH with IMEM_RDY, no redirect, STALL=0: IF_VALID=1, IF_PC=FADDR; PC<=FADDR+4, FADDR<=FADDR+4; remain FETCH (one instruction per cycle at zero-wait memory).
REQ-023 FETCH with IMEM_RDY, no redirect, STALL=1: IF_VALID=1, IF_PC=FADDR; go HOLD; PC, FADDR unchanged.
REQ-024 HOLD: IMEM_REQ=0, IF_VALID=1, IF_PC=FADDR; STALL=0 -> PC, FADDR <= FADDR+4, go FETCH; STALL=1 -> remain.
REQ-025 Redirect in FETCH with IMEM_RDY=1, or in HOLD: FLUSH=1, IF_VALID=0, PC<=target, FADDR<=target, next FETCH.
REQ-026 Redirect in FETCH with IMEM_RDY=0: FLUSH=1, IF_VALID=0, PC<=target, FADDR held, next DRAIN.
REQ-027 DRAIN: IMEM_REQ=1, IMEM_ADDR=FADDR, IF_VALID=0; on IMEM_RDY the returned word is discarded, FADDR<=PC, go FETCH.
REQ-028 Redirect in DRAIN: FLUSH=1, PC<=target (latest redirect wins), remain in DRAIN until IMEM_RDY.
REQ-029 Redirect SHALL override STALL in every state except BOOT.
REQ-030 FLUSH SHALL be 0 in any cycle without redirect; MISALIGN SHALL be 0 without redirect.

Reset
REQ-031 RST_N=0 SHALL immediately force state BOOT, PC=FADDR=RESET_VEC, IMEM_REQ=0, IF_VALID=0, IF_PC=RESET_VEC, FLUSH=0, MISALIGN=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the outstanding request; IMEM_RDY during reset is ignored.
REQ-033 First IMEM_REQ SHALL occur in the second rising edge after RST_N deasserts (one BOOT cycle).

Verification
REQ-034 Reset release, IMEM_RDY=1 constant, STALL=0 -> IF_PC sequence 0x0, 0x4, 0x8, one per cycle, IF_VALID=1.
REQ-035 At IF_PC=0x8, STALL=1 for 3 cycles -> IF_PC stays 0x8, IMEM_REQ=0; after release, next IF_PC=0xC.
REQ-036 TRAP (MTVEC=0x100) and BR_TAKEN (0x40) in the same cycle -> FLUSH=1, IF_VALID=0, next fetch address 0x100.
REQ-037 IMEM_RDY=0 with FADDR=0x20, JMP_VALID target 0x80 -> DRAIN; IMEM_ADDR stays 0x20 until IMEM_RDY, word dropped, next IMEM_ADDR=0x80.
REQ-038 BR_TARGET=0x43 -> MISALIGN pulse, next fetch address 0x40; PC=0xFFFF_FFFC sequential -> next 0x0.
REQ-039 RST_N low during DRAIN -> outputs reach reset values without a clock edge; fetch resumes at RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, sequences IMEM requests and
// applies trap/mret/branch/jump redirects, draining any in-flight fetch first.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        mret,
    input  logic [31:0] mepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Handshake: a fetch completes in any cycle where imem_req && imem_rdy;
    // imem_addr stays on faddr until that happens. Decode takes the presented
    // instruction in any cycle where if_valid && !stall.

    state_t      state;
    logic [31:0] pc;
    logic [31:0] faddr;

    logic        redirect;
    logic        take_redirect;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic [31:0] seq_addr;

    always_comb begin
        redirect = trap | mret | br_taken | jmp_valid;
        if (trap)          raw_target = mtvec;
        else if (mret)     raw_target = mepc;
        else if (br_taken) raw_target = br_target;
        else               raw_target = jmp_target;
        target        = {raw_target[31:2], 2'b00};
        seq_addr      = faddr + 32'd4;
        take_redirect = redirect && (state != BOOT);
    end

    always_comb begin
        imem_req  = (state == FETCH) || (state == DRAIN);
        imem_addr = faddr;
        if_pc     = faddr;
        if_valid  = !take_redirect &&
                    (((state == FETCH) && imem_rdy) || (state == HOLD));
        flush     = take_redirect;
        misalign  = take_redirect && (raw_target[1:0] != 2'b00);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_VEC;
            faddr <= RESET_VEC;
        end else begin
            case (state)
                BOOT: begin
                    faddr <= pc;
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_rdy) begin
                            faddr <= target;
                        end else begin
                            // The old request is still owed a response; swallow it first.
                            state <= DRAIN;
                        end
                    end else if (imem_rdy) begin
                        if (stall) begin
                            state <= HOLD;
                        end else begin
                            pc    <= seq_addr;
                            faddr <= seq_addr;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        faddr <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc    <= seq_addr;
                        faddr <= seq_addr;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_rdy) begin
                        faddr <= redirect ? target : pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: stimulus pushes expected decode PCs, a
// negedge monitor pops them whenever decode accepts an instruction.
module tb_pc_fetch_ctrl;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        trap;
    logic [31:0] mtvec;
    logic        mret;
    logic [31:0] mepc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        flush;
    logic        misalign;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .trap(trap), .mtvec(mtvec), .mret(mret), .mepc(mepc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .if_pc(if_pc), .if_valid(if_valid), .flush(flush),
        .misalign(misalign), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        trap      = 1'b0;
        mret      = 1'b0;
        br_taken  = 1'b0;
        jmp_valid = 1'b0;
    endtask

    // monitor: every instruction accepted by decode must match the queue head
    always @(negedge clk) begin
        if (rst_n && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_if_pc", if_pc, 32'hxxxx_xxxx);
            end else begin
                check("if_pc_seq", if_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_rdy = 1'b1;
        clear_redirects();
        br_target = '0; jmp_target = '0; mtvec = '0; mepc = '0;
        trap = 1'b1; mtvec = 32'h0000_0100;   // must be ignored under reset
        cyc(); cyc();
        #1;
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_BOOT});
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        trap = 1'b0;

        // zero-wait sequential fetch, then a 3-cycle stall at 0x8
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        cyc(); rst_n = 1'b1; #1;
        check("boot_no_req", {31'd0, imem_req}, 32'd0);
        check("boot_state", {30'd0, dbg_state}, {30'd0, S_BOOT});
        cyc(); #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        cyc();
        cyc(); stall = 1'b1; #1;
        check("stall_if_pc", if_pc, 32'h8);
        cyc(); #1;
        check("hold_state", {30'd0, dbg_state}, {30'd0, S_HOLD});
        check("hold_no_req", {31'd0, imem_req}, 32'd0);
        check("hold_if_pc", if_pc, 32'h8);
        cyc(); #1;
        check("hold2_if_valid", {31'd0, if_valid}, 32'd1);
        cyc(); stall = 1'b0;
        cyc(); #1;
        check("after_stall_addr", imem_addr, 32'hC);

        // trap beats branch in the same cycle
        cyc(); trap = 1'b1; mtvec = 32'h100; br_taken = 1'b1; br_target = 32'h40; #1;
        check("trap_flush", {31'd0, flush}, 32'd1);
        check("trap_if_valid", {31'd0, if_valid}, 32'd0);
        check("trap_misalign", {31'd0, misalign}, 32'd0);
        cyc(); clear_redirects(); jmp_valid = 1'b1; jmp_target = 32'h20; #1;
        check("trap_next_addr", imem_addr, 32'h100);

        // redirect with the fetch of 0x20 still outstanding
        cyc(); imem_rdy = 1'b0; jmp_target = 32'h80; #1;
        check("pre_drain_addr", imem_addr, 32'h20);
        check("pre_drain_flush", {31'd0, flush}, 32'd1);
        cyc(); clear_redirects(); #1;
        check("drain_state", {30'd0, dbg_state}, {30'd0, S_DRAIN});
        check("drain_addr_held", imem_addr, 32'h20);
        check("drain_no_flush", {31'd0, flush}, 32'd0);
        cyc(); imem_rdy = 1'b1; #1;
        check("drain_drop_valid", {31'd0, if_valid}, 32'd0);
        exp_q.push_back(32'h80);
        cyc(); #1;
        check("post_drain_addr", imem_addr, 32'h80);

        // misaligned branch target, then PC wrap at the top of the space
        cyc(); br_taken = 1'b1; br_target = 32'h43; #1;
        check("misalign_pulse", {31'd0, misalign}, 32'd1);
        cyc(); br_target = 32'hFFFF_FFFC; #1;
        check("misalign_addr", imem_addr, 32'h40);
        check("misalign_clear", {31'd0, misalign}, 32'd0);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        cyc(); clear_redirects();
        cyc(); #1;
        check("wrap_addr", imem_addr, 32'h0);

        // reset taken in DRAIN with a second redirect pending
        cyc(); imem_rdy = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h200;
        cyc(); jmp_valid = 1'b0; mret = 1'b1; mepc = 32'h300; #1;
        check("drain_redirect_flush", {31'd0, flush}, 32'd1);
        cyc(); mret = 1'b0; imem_rdy = 1'b1; rst_n = 1'b0; #1;
        check("async_rst_state", {30'd0, dbg_state}, {30'd0, S_BOOT});
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_if_pc", if_pc, 32'h0);
        cyc();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        cyc(); rst_n = 1'b1;
        cyc(); #1;
        check("resume_addr", imem_addr, 32'h0);
        cyc();
        cyc(); imem_rdy = 1'b0;
        cyc(); cyc();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
